// File: rtl/imem_dbg_loader_if.sv
// AHB-Lite master/slave bundle between the image loader and the imem_dbg_ahb slave port.
interface imem_dbg_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HSEL;
  logic                  HREADY;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HMASTLOCK;
  logic [31:0]           HWDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HADDR, HSEL, HREADY, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    input  HREADYOUT, HRESP
  );

  modport slave (
    input  HADDR, HSEL, HREADY, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA,
    output HREADYOUT, HRESP
  );
endinterface

// File: rtl/imem_dbg_loader.sv
// Turns framed byte packets (SYNC, ADDR, CNT, words) into single 32-bit AHB-Lite writes
// into instruction RAM, holding the core in reset via busy while a frame is in flight.
module imem_dbg_loader #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  imem_dbg_loader_if.master   ahb,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WORD, S_APH, S_DPH, S_DONE, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            byteIdx_q, byteIdx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           word_q, word_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic                  accept;
  logic [31:0]           shifted;
  logic [TW-1:0]         timerInc;

  assign accept   = in_valid & in_ready;
  assign shifted  = {in_data, word_q[31:8]};
  assign timerInc = timer_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      byteIdx_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      byteIdx_q <= byteIdx_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  // Header and data bytes both arrive LSB first, so one shift register serves both.
  always_comb begin
    state_d   = state_q;
    byteIdx_d = byteIdx_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    err_d     = err_q;
    timer_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d   = S_HDR;
          byteIdx_d = '0;
          err_d     = 1'b0;
        end
      end
      S_HDR: begin
        if (accept) begin
          byteIdx_d = byteIdx_q + 3'd1;
          if (byteIdx_q < 3'd4) word_d = shifted;
          if (byteIdx_q == 3'd3) addr_d = {shifted[ADDR_WIDTH-1:2], 2'b00};
          if (byteIdx_q == 3'd4) cnt_d[7:0] = in_data;
          if (byteIdx_q == 3'd5) begin
            cnt_d[15:8] = in_data;
            byteIdx_d   = '0;
            state_d     = ({in_data, cnt_q[7:0]} == 16'd0) ? S_DONE : S_WORD;
          end
        end else if (timerInc == TW'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timerInc;
        end
      end
      S_WORD: begin
        if (accept) begin
          word_d    = shifted;
          byteIdx_d = byteIdx_q + 3'd1;
          if (byteIdx_q == 3'd3) begin
            byteIdx_d = '0;
            state_d   = S_APH;
          end
        end else if (timerInc == TW'(TIMEOUT)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timerInc;
        end
      end
      S_APH: begin
        if (ahb.HREADYOUT) state_d = S_DPH;
      end
      S_DPH: begin
        if (ahb.HREADYOUT) begin
          if (ahb.HRESP) begin
            state_d = S_ERR;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(4);
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? S_DONE : S_WORD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Bus outputs are gated by phase so nothing stale leaks onto HADDR/HWDATA between writes.
  always_comb begin
    in_ready   = (state_q == S_IDLE) || (state_q == S_HDR) || (state_q == S_WORD);
    busy       = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    done       = (state_q == S_DONE);
    err        = err_q;
    ahb.HSEL   = 1'b0;
    ahb.HWRITE = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HADDR  = '0;
    ahb.HWDATA = '0;
    if (state_q == S_APH) begin
      ahb.HSEL   = 1'b1;
      ahb.HWRITE = 1'b1;
      ahb.HTRANS = 2'b10;
      ahb.HADDR  = addr_q;
    end
    if (state_q == S_DPH) ahb.HWDATA = word_q;
  end

  assign ahb.HREADY    = ahb.HREADYOUT;
  assign ahb.HSIZE     = 3'b010;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_imem_dbg_loader.sv
// Scoreboard bench for imem_dbg_loader: stimulus pushes expected AHB writes, a bus monitor pops them.
module tb_imem_dbg_loader;

  localparam int TIMEOUT = 1024;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic [7:0] inData;
  logic       inReady;
  logic       busy;
  logic       done;
  logic       err;

  int vecCnt  = 0;
  int missCnt = 0;
  int doneCnt = 0;
  int waitA   = 0;
  int waitD   = 0;
  int errIdx  = -1;
  int writeIdx = 0;
  wr_t expQ[$];

  imem_dbg_loader_if #(.ADDR_WIDTH(16)) ahb ();

  imem_dbg_loader #(
    .ADDR_WIDTH(16),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(inValid),
    .in_data (inData),
    .in_ready(inReady),
    .ahb     (ahb.master),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCnt++;
    if (act !== exp) begin
      missCnt++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: wait states and error injection are chosen by the stimulus thread.
  initial begin
    int aCnt;
    int dCnt;
    bit dphPending;
    aCnt = 0;
    dCnt = 0;
    dphPending = 0;
    ahb.HREADYOUT = 1'b1;
    ahb.HRESP     = 1'b0;
    @(posedge reset);
    forever begin
      @(posedge clk);
      #1;
      if (dphPending) begin
        if (dCnt < waitD) begin
          ahb.HREADYOUT = 1'b0;
          ahb.HRESP     = 1'b0;
          dCnt++;
        end else begin
          ahb.HREADYOUT = 1'b1;
          ahb.HRESP     = (writeIdx == errIdx);
          dCnt = 0;
          dphPending = 0;
          writeIdx++;
        end
      end else if (ahb.HTRANS == 2'b10) begin
        ahb.HRESP = 1'b0;
        if (aCnt < waitA) begin
          ahb.HREADYOUT = 1'b0;
          aCnt++;
        end else begin
          ahb.HREADYOUT = 1'b1;
          aCnt = 0;
          dphPending = 1;
        end
      end else begin
        ahb.HREADYOUT = 1'b1;
        ahb.HRESP     = 1'b0;
      end
    end
  end

  // Monitor: compares every address/data phase cycle against the queue head.
  initial begin
    bit dphExp;
    dphExp = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (done) begin
          doneCnt++;
          checkOutput("busyAtDone", 32'(busy), 32'd0);
        end
        if (dphExp) begin
          checkOutput("dphHtrans", 32'(ahb.HTRANS), 32'd0);
          checkOutput("dphInReady", 32'(inReady), 32'd0);
          if (expQ.size() != 0) checkOutput("hwdata", ahb.HWDATA, expQ[0].data);
          if (ahb.HREADYOUT) begin
            if (expQ.size() != 0) void'(expQ.pop_front());
            dphExp = 0;
          end
        end else if (ahb.HTRANS == 2'b10) begin
          checkOutput("writeExpected", 32'(expQ.size() != 0), 32'd1);
          checkOutput("hsel", 32'(ahb.HSEL), 32'd1);
          checkOutput("hwrite", 32'(ahb.HWRITE), 32'd1);
          checkOutput("aphInReady", 32'(inReady), 32'd0);
          if (expQ.size() != 0) checkOutput("haddr", 32'(ahb.HADDR), 32'(expQ[0].addr));
          if (ahb.HREADYOUT) dphExp = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    inValid = 1'b1;
    inData  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inReady) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checkOutput("byteAccepted", 32'd0, 32'd1);
    end
    inValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    applyStimulus(w[7:0]);
    applyStimulus(w[15:8]);
    applyStimulus(w[23:16]);
    applyStimulus(w[31:24]);
  endtask

  task automatic sendHeader(input logic [31:0] addr, input logic [15:0] cnt);
    applyStimulus(8'hA5);
    sendWord(addr);
    applyStimulus(cnt[7:0]);
    applyStimulus(cnt[15:8]);
  endtask

  task automatic pushWrite(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic waitDone(input int n);
    for (int i = 0; i < 200; i++) begin
      if (doneCnt >= n) break;
      @(negedge clk);
    end
    checkOutput("doneCount", 32'(doneCnt), 32'(n));
    @(negedge clk);
    checkOutput("busyAfterDone", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    #3;
    checkOutput("rstHtrans", 32'(ahb.HTRANS), 32'd0);
    checkOutput("rstHsel", 32'(ahb.HSEL), 32'd0);
    checkOutput("rstHwrite", 32'(ahb.HWRITE), 32'd0);
    checkOutput("rstHsize", 32'(ahb.HSIZE), 32'd2);
    checkOutput("rstHprot", 32'(ahb.HPROT), 32'd3);
    checkOutput("rstHready", 32'(ahb.HREADY), 32'd1);
    checkOutput("rstInReady", 32'(inReady), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    #20;
    @(negedge clk);
    reset = 1'b1;

    // Single write, zero-wait slave
    pushWrite(16'h0100, 32'h0000_0013);
    applyStimulus(8'hA5);
    @(negedge clk);
    checkOutput("busyInFrame", 32'(busy), 32'd1);
    sendWord(32'h0000_0100);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    sendWord(32'h0000_0013);
    waitDone(1);

    // Three words wrapping through the top of the address space
    pushWrite(16'hFFFC, 32'h1122_3344);
    pushWrite(16'h0000, 32'h5566_7788);
    pushWrite(16'h0004, 32'h99AA_BBCC);
    sendHeader(32'h0000_FFFC, 16'd3);
    sendWord(32'h1122_3344);
    sendWord(32'h5566_7788);
    sendWord(32'h99AA_BBCC);
    waitDone(2);
    repeat (5) @(negedge clk);
    checkOutput("singleDonePulse", 32'(doneCnt), 32'd2);

    // Wait states in both phases; upper address bits and [1:0] are discarded
    waitA = 5;
    waitD = 3;
    pushWrite(16'h0200, 32'hDEAD_BEEF);
    sendHeader(32'h1234_0203, 16'd1);
    sendWord(32'hDEAD_BEEF);
    waitDone(3);
    waitA = 0;
    waitD = 0;

    // Error response on the 2nd of 3 words
    errIdx = writeIdx + 1;
    pushWrite(16'h0400, 32'h0102_0304);
    pushWrite(16'h0404, 32'hCAFE_F00D);
    sendHeader(32'h0000_0400, 16'd3);
    sendWord(32'h0102_0304);
    sendWord(32'hCAFE_F00D);
    sendWord(32'h5566_7788);
    repeat (20) @(negedge clk);
    checkOutput("errAfterHresp", 32'(err), 32'd1);
    checkOutput("noDoneOnErr", 32'(doneCnt), 32'd3);
    errIdx = -1;
    applyStimulus(8'hA5);
    @(negedge clk);
    checkOutput("errClearedBySync", 32'(err), 32'd0);
    sendWord(32'h0000_0000);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    waitDone(4);

    // Timeout after 2 data bytes
    sendHeader(32'h0000_0200, 16'd1);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    repeat (TIMEOUT + 20) @(negedge clk);
    checkOutput("errTimeout", 32'(err), 32'd1);
    checkOutput("inReadyIdle", 32'(inReady), 32'd1);
    checkOutput("busyTimeout", 32'(busy), 32'd0);
    checkOutput("noDoneTimeout", 32'(doneCnt), 32'd4);

    // Leading junk then an empty frame
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    @(negedge clk);
    checkOutput("junkIgnored", 32'(busy), 32'd0);
    applyStimulus(8'hA5);
    @(negedge clk);
    checkOutput("errClearedJunk", 32'(err), 32'd0);
    sendWord(32'h0000_0000);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    waitDone(5);

    repeat (10) @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    checkOutput("writeCount", 32'(writeIdx), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
